// File: rtl/decode_issue_unit_if.sv
// rtl/decode_issue_unit_if.sv - IF-side and EX-side handshake bundle of the decode/issue stage
interface decode_issue_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [31:0]       in_inst;

   logic              out_valid;
   logic              out_ready;
   logic [5:0]        out_funct;
   logic [4:0]        out_shamt;
   logic [DATA_W-1:0] out_operand_1;
   logic [DATA_W-1:0] out_operand_2;
   logic              out_mem_read;
   logic              out_mem_write;
   logic              out_mem_sign_ext;
   logic [3:0]        out_mem_sel;
   logic [DATA_W-1:0] out_mem_wdata;
   logic              out_reg_write_en;
   logic [4:0]        out_reg_write_addr;
   logic [ADDR_W-1:0] out_pc;

   modport master (
      output in_valid, in_addr, in_inst, out_ready,
      input  in_ready, out_valid, out_funct, out_shamt, out_operand_1, out_operand_2,
             out_mem_read, out_mem_write, out_mem_sign_ext, out_mem_sel, out_mem_wdata,
             out_reg_write_en, out_reg_write_addr, out_pc
   );

   modport slave (
      input  in_valid, in_addr, in_inst, out_ready,
      output in_ready, out_valid, out_funct, out_shamt, out_operand_1, out_operand_2,
             out_mem_read, out_mem_write, out_mem_sign_ext, out_mem_sel, out_mem_wdata,
             out_reg_write_en, out_reg_write_addr, out_pc
   );
endinterface

// File: rtl/decode_issue_unit.sv
// rtl/decode_issue_unit.sv - MIPS-style decode/issue stage with prioritised forwarding,
// counted load-use interlock and an ID/EX register handshaking to EX.
module decode_issue_unit #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FWD_CH     = 2,
   parameter int LOAD_STALL = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   decode_issue_unit_if.slave       bus,
   input  logic                     flush_i,
   output logic                     reg_read_en_1_o,
   output logic                     reg_read_en_2_o,
   output logic [4:0]               reg_addr_1_o,
   output logic [4:0]               reg_addr_2_o,
   input  logic [DATA_W-1:0]        reg_data_1_i,
   input  logic [DATA_W-1:0]        reg_data_2_i,
   input  logic [FWD_CH-1:0]        fwd_valid_i,
   input  logic [FWD_CH-1:0]        fwd_is_load_i,
   input  logic [5*FWD_CH-1:0]      fwd_addr_i,
   input  logic [DATA_W*FWD_CH-1:0] fwd_data_i,
   output logic                     stall_request_o,
   output logic                     branch_flag_o,
   output logic [ADDR_W-1:0]        branch_addr_o
);

   localparam int CNT_W = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20, OP_LH   = 6'h21, OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU  = 6'h25, OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29, OP_SW   = 6'h2B;

   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA  = 6'h03, F_JR  = 6'h08;
   localparam logic [5:0] F_JALR = 6'h09, F_ADD = 6'h20, F_ADDU = 6'h21, F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25, F_XOR = 6'h26, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

   typedef enum logic {S_RUN, S_LSTALL} state_t;

   typedef struct packed {
      logic [5:0]        funct;
      logic [4:0]        shamt;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic              mem_read;
      logic              mem_write;
      logic              mem_sign_ext;
      logic [3:0]        mem_sel;
      logic [DATA_W-1:0] mem_wdata;
      logic              reg_write_en;
      logic [4:0]        reg_write_addr;
      logic [ADDR_W-1:0] pc;
   } payload_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q;
   payload_t         pay_q, pay_d;

   logic [5:0]  opcode, funct_f;
   logic [4:0]  rs, rt, rd, shamt_f;
   logic [15:0] imm;

   assign opcode  = bus.in_inst[31:26];
   assign rs      = bus.in_inst[25:21];
   assign rt      = bus.in_inst[20:16];
   assign rd      = bus.in_inst[15:11];
   assign shamt_f = bus.in_inst[10:6];
   assign funct_f = bus.in_inst[5:0];
   assign imm     = bus.in_inst[15:0];

   logic [DATA_W-1:0] simm, zimm, luimm;
   logic [ADDR_W-1:0] pc_plus4, pc_plus8, br_target, j_target;

   assign simm      = {{(DATA_W-16){imm[15]}}, imm};
   assign zimm      = {{(DATA_W-16){1'b0}}, imm};
   assign luimm     = {imm, {(DATA_W-16){1'b0}}};
   assign pc_plus4  = bus.in_addr + ADDR_W'(4);
   assign pc_plus8  = bus.in_addr + ADDR_W'(8);
   assign br_target = pc_plus4 + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
   assign j_target  = {pc_plus4[ADDR_W-1:28], bus.in_inst[25:0], 2'b00};

   // Bit DATA_W flags that the winning source is a load whose data is not yet available.
   function automatic logic [DATA_W:0] resolve(
      input logic [4:0]               src,
      input logic [DATA_W-1:0]        rf_val,
      input logic [FWD_CH-1:0]        v,
      input logic [FWD_CH-1:0]        ld,
      input logic [5*FWD_CH-1:0]      a,
      input logic [DATA_W*FWD_CH-1:0] d
   );
      logic [DATA_W:0] r;
      r = {1'b0, rf_val};
      for (int i = FWD_CH - 1; i >= 0; i--) begin
         if (v[i] && (a[5*i +: 5] == src)) r = {ld[i], d[DATA_W*i +: DATA_W]};
      end
      if (src == 5'd0) r = '0;
      return r;
   endfunction

   logic        re1, re2, use_imm, wr_en, link, lui, mem_rd, mem_wr, sx;
   logic        br_eq, br_ne, br_lez, br_gtz, jmp, jreg, is_r;
   logic [5:0]  dec_funct;
   logic [4:0]  wr_addr;
   logic [3:0]  sel;
   logic [DATA_W-1:0] imm_val;

   always_comb begin
      re1 = 1'b0; re2 = 1'b0; use_imm = 1'b0; wr_en = 1'b0; wr_addr = rt;
      link = 1'b0; lui = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; sx = 1'b0; sel = 4'h0;
      br_eq = 1'b0; br_ne = 1'b0; br_lez = 1'b0; br_gtz = 1'b0; jmp = 1'b0; jreg = 1'b0;
      is_r = 1'b0; dec_funct = F_SLL; imm_val = simm;
      case (opcode)
         OP_SPECIAL: begin
            is_r      = 1'b1;
            dec_funct = funct_f;
            re1       = !(funct_f inside {F_SLL, F_SRL, F_SRA});
            re2       = !(funct_f inside {F_JR, F_JALR});
            wr_en     = (funct_f != F_JR);
            wr_addr   = rd;
            if (funct_f inside {F_JR, F_JALR}) begin
               jreg      = 1'b1;
               dec_funct = F_ADDU;
               link      = (funct_f == F_JALR);
            end
         end
         OP_J:    jmp = 1'b1;
         OP_JAL:  begin jmp = 1'b1; link = 1'b1; wr_en = 1'b1; wr_addr = 5'd31; dec_funct = F_ADDU; end
         OP_BEQ:  begin re1 = 1'b1; re2 = 1'b1; br_eq = 1'b1; end
         OP_BNE:  begin re1 = 1'b1; re2 = 1'b1; br_ne = 1'b1; end
         OP_BLEZ: begin re1 = 1'b1; br_lez = 1'b1; end
         OP_BGTZ: begin re1 = 1'b1; br_gtz = 1'b1; end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
            re1 = 1'b1; use_imm = 1'b1; wr_en = 1'b1;
            case (opcode)
               OP_ADDI:  dec_funct = F_ADD;
               OP_SLTI:  dec_funct = F_SLT;
               OP_SLTIU: dec_funct = F_SLTU;
               OP_ANDI:  begin dec_funct = F_AND; imm_val = zimm; end
               OP_ORI:   begin dec_funct = F_OR;  imm_val = zimm; end
               OP_XORI:  begin dec_funct = F_XOR; imm_val = zimm; end
               default:  dec_funct = F_ADDU;
            endcase
         end
         OP_LUI: begin use_imm = 1'b1; lui = 1'b1; wr_en = 1'b1; dec_funct = F_ADDU; imm_val = luimm; end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            re1 = 1'b1; use_imm = 1'b1; wr_en = 1'b1; mem_rd = 1'b1; dec_funct = F_ADDU;
            sx  = (opcode == OP_LB) || (opcode == OP_LH);
            sel = (opcode == OP_LW) ? 4'hF : ((opcode == OP_LH || opcode == OP_LHU) ? 4'h3 : 4'h1);
         end
         OP_SB, OP_SH, OP_SW: begin
            re1 = 1'b1; re2 = 1'b1; use_imm = 1'b1; mem_wr = 1'b1; dec_funct = F_ADDU;
            sel = (opcode == OP_SW) ? 4'hF : ((opcode == OP_SH) ? 4'h3 : 4'h1);
         end
         default: ;
      endcase
   end

   logic [DATA_W:0]   res1, res2;
   logic [DATA_W-1:0] src1, src2;
   logic              hazard, taken, in_ready, fire;
   logic [ADDR_W-1:0] target;

   always_comb begin
      res1 = resolve(rs, reg_data_1_i, fwd_valid_i, fwd_is_load_i, fwd_addr_i, fwd_data_i);
      res2 = resolve(rt, reg_data_2_i, fwd_valid_i, fwd_is_load_i, fwd_addr_i, fwd_data_i);
   end

   assign src1   = res1[DATA_W-1:0];
   assign src2   = res2[DATA_W-1:0];
   assign hazard = (re1 & res1[DATA_W]) | (re2 & res2[DATA_W]);

   assign taken = jmp | jreg
                | (br_eq  & (src1 == src2))
                | (br_ne  & (src1 != src2))
                | (br_lez & (src1[DATA_W-1] | (src1 == '0)))
                | (br_gtz & ~src1[DATA_W-1] & (src1 != '0));
   assign target = jmp ? j_target : (jreg ? ADDR_W'(src1) : br_target);

   always_comb begin
      pay_d                = '0;
      pay_d.funct          = dec_funct;
      pay_d.shamt          = is_r ? shamt_f : 5'd0;
      pay_d.op1            = link ? DATA_W'(pc_plus8) : (lui ? '0 : src1);
      pay_d.op2            = use_imm ? imm_val : (link ? '0 : src2);
      pay_d.mem_read       = mem_rd;
      pay_d.mem_write      = mem_wr;
      pay_d.mem_sign_ext   = sx;
      pay_d.mem_sel        = sel;
      pay_d.mem_wdata      = src2;
      pay_d.reg_write_en   = wr_en && (wr_addr != 5'd0);
      pay_d.reg_write_addr = (wr_en && (wr_addr != 5'd0)) ? wr_addr : 5'd0;
      pay_d.pc             = bus.in_addr;
   end

   // Flush outranks everything; reset keeps the stage from accepting anything.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_ready = 1'b0;
      if (flush_i) begin
         state_d = S_RUN;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_RUN: begin
               in_ready = ~hazard & (~out_valid_q | bus.out_ready);
               if (bus.in_valid && hazard) begin
                  state_d = S_LSTALL;
                  cnt_d   = CNT_W'(LOAD_STALL - 1);
               end
            end
            S_LSTALL: begin
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               else state_d = S_RUN;
            end
         endcase
      end
      if (rst) in_ready = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fire = bus.in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         pay_q       <= '0;
      end else if (flush_i) begin
         out_valid_q <= 1'b0;
      end else if (fire) begin
         out_valid_q <= 1'b1;
         pay_q       <= pay_d;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready           = in_ready;
   assign bus.out_valid          = out_valid_q;
   assign bus.out_funct          = pay_q.funct;
   assign bus.out_shamt          = pay_q.shamt;
   assign bus.out_operand_1      = pay_q.op1;
   assign bus.out_operand_2      = pay_q.op2;
   assign bus.out_mem_read       = pay_q.mem_read;
   assign bus.out_mem_write      = pay_q.mem_write;
   assign bus.out_mem_sign_ext   = pay_q.mem_sign_ext;
   assign bus.out_mem_sel        = pay_q.mem_sel;
   assign bus.out_mem_wdata      = pay_q.mem_wdata;
   assign bus.out_reg_write_en   = pay_q.reg_write_en;
   assign bus.out_reg_write_addr = pay_q.reg_write_addr;
   assign bus.out_pc             = pay_q.pc;

   assign reg_read_en_1_o = re1;
   assign reg_read_en_2_o = re2;
   assign reg_addr_1_o    = rs;
   assign reg_addr_2_o    = rt;
   assign stall_request_o = bus.in_valid & ~in_ready;
   assign branch_flag_o   = fire & taken;
   assign branch_addr_o   = (fire & taken) ? target : '0;

endmodule
